// File: rtl/minmax_search_64.sv
// minmax_search_64 -- sequential max/min search over an operand memory,
// using an external multi-cycle double-precision comparator.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   start, len, mode    request; len elements at 0..len-1, mode 0=max 1=min
//   rd_en, rd_addr      operand memory read port (data returns next cycle)
//   rd_data             operand memory read data
//   cmp_sta             one-cycle compare request
//   cmp_a, cmp_b        comparator operands (candidate, current best)
//   cmp_agb, cmp_alb    comparator flags, qualified by cmp_done
//   cmp_done            comparator completion strobe
//   busy, done          status; done is a one-cycle pulse
//   result, result_idx  extreme value and its address, held until next start
//   err                 len=0 or comparator timeout
module minmax_search_64 #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 8,
  parameter int TMO    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] len,
  input  logic              mode,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              cmp_sta,
  output logic [DATA_W-1:0] cmp_a,
  output logic [DATA_W-1:0] cmp_b,
  input  logic              cmp_agb,
  input  logic              cmp_alb,
  input  logic              cmp_done,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic [ADDR_W-1:0] result_idx,
  output logic              err
);

  localparam int TW = $clog2(TMO + 1);
  localparam logic [TW-1:0]     TMO_LAST = TW'(TMO - 1);
  localparam logic [TW-1:0]     T_ONE    = TW'(1);
  localparam logic [ADDR_W-1:0] A_ONE    = ADDR_W'(1);

  typedef enum logic [2:0] {
    IDLE, FETCH0, LOAD0, FETCH, ISSUE, WAIT, DONE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] len_q;
  logic              mode_q;
  logic [ADDR_W-1:0] i;
  logic [ADDR_W-1:0] best_idx;
  logic [DATA_W-1:0] best;
  logic [DATA_W-1:0] cand;
  logic [TW-1:0]     tmo_cnt;

  logic [ADDR_W-1:0] i_nxt;
  logic              take;

  assign i_nxt = i + A_ONE;
  // Strict compare only: ties and unordered (NaN) keep the earlier index.
  assign take  = mode_q ? cmp_alb : cmp_agb;

  // rd_data is only valid during ISSUE; afterwards the latched copy keeps
  // cmp_a stable for the whole compare. best does not change until WAIT ends.
  assign cmp_a = (state == ISSUE) ? rd_data : cand;
  assign cmp_b = best;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      len_q      <= '0;
      mode_q     <= 1'b0;
      i          <= '0;
      best_idx   <= '0;
      best       <= '0;
      cand       <= '0;
      tmo_cnt    <= '0;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      cmp_sta    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      result     <= '0;
      result_idx <= '0;
      err        <= 1'b0;
    end else begin
      // strobes default low; outputs are registered on entry to a state
      rd_en   <= 1'b0;
      cmp_sta <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            len_q      <= len;
            mode_q     <= mode;
            err        <= 1'b0;
            result     <= '0;
            result_idx <= '0;
            busy       <= 1'b1;
            if (len == '0) begin
              err   <= 1'b1;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              rd_en   <= 1'b1;
              rd_addr <= '0;
              state   <= FETCH0;
            end
          end
        end
        FETCH0: state <= LOAD0;
        LOAD0: begin
          best     <= rd_data;
          best_idx <= '0;
          i        <= A_ONE;
          if (len_q == A_ONE) begin
            // result is loaded together with done so it is valid on the pulse
            result     <= rd_data;
            result_idx <= '0;
            done       <= 1'b1;
            state      <= DONE;
          end else begin
            rd_en   <= 1'b1;
            rd_addr <= A_ONE;
            state   <= FETCH;
          end
        end
        FETCH: begin
          cmp_sta <= 1'b1;
          state   <= ISSUE;
        end
        ISSUE: begin
          cand    <= rd_data;
          tmo_cnt <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          if (cmp_done) begin
            if (take) begin
              best     <= cand;
              best_idx <= i;
            end
            i <= i_nxt;
            if (i_nxt == len_q) begin
              result     <= take ? cand : best;
              result_idx <= take ? i : best_idx;
              done       <= 1'b1;
              state      <= DONE;
            end else begin
              rd_en   <= 1'b1;
              rd_addr <= i_nxt;
              state   <= FETCH;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            // TMO cycles spent in WAIT: give up with the best found so far
            err        <= 1'b1;
            result     <= best;
            result_idx <= best_idx;
            done       <= 1'b1;
            state      <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + T_ONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
